log2_stage_arbiter: RTL and testbench

- Shares one stage1_log2_approx datapath (3-cycle, globally enabled pipeline, Q8.8) between two vector-packet requesters.
- Arbitration is round-robin at packet granularity, so each softmax vector passes through the pipeline contiguously.
- Carries requester ID and last flag through a sideband shift register aligned with the pipeline.
- Drives the pipeline's global en from downstream backpressure.
- Sits between the per-head input buffers and stage 2 of the softmax approximation.

---
 rtl/log2_stage_arbiter_pkg.sv | 20 ++
 rtl/log2_sideband_delay.sv | 36 +++
 rtl/log2_stage_arbiter.sv | 115 +++++++++++
 tb/tb_log2_stage_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log2_stage_arbiter_pkg.sv
// Shared types and defaults for the log2 stage arbiter and its sideband delay line.
package log2_stage_arbiter_pkg;

    localparam int DW_DEF  = 16;
    localparam int LAT_DEF = 3;
    localparam int SB_W    = 1 + 1 + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic vld;
        logic id;
        logic last;
    } sb_t;

endpackage

// File: rtl/log2_sideband_delay.sv
// LAT-deep enabled shift register with synchronous clear; tracks per-beat tags
// alongside a globally enabled datapath pipeline.
module log2_sideband_delay
    import log2_stage_arbiter_pkg::*;
#(
    parameter int W   = SB_W,
    parameter int LAT = LAT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         any_o
);

    logic [W-1:0] sr_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) sr_q[i] <= '0;
        end else if (en_i) begin
            sr_q[0] <= d_i;
            for (int i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[LAT-1];

    // Entries are all-zero when empty, so any set bit means occupancy.
    always_comb begin
        any_o = 1'b0;
        for (int i = 0; i < LAT; i++) any_o = any_o | (|sr_q[i]);
    end

endmodule

// File: rtl/log2_stage_arbiter.sv
// Packet-granular round-robin arbiter sharing one log2 datapath between two
// vector requesters, with requester ID and last flag carried in a sideband.
module log2_stage_arbiter
    import log2_stage_arbiter_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_last,
    input  logic [DW-1:0] req0_in_0,
    input  logic [DW-1:0] req0_in_1,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_last,
    input  logic [DW-1:0] req1_in_0,
    input  logic [DW-1:0] req1_in_1,
    output logic          pipe_en,
    output logic          pipe_valid_in,
    output logic [DW-1:0] pipe_in_0,
    output logic [DW-1:0] pipe_in_1,
    input  logic          pipe_valid_out,
    input  logic [DW-1:0] pipe_log_in_0,
    input  logic [DW-1:0] pipe_in_0_bypass,
    input  logic [DW-1:0] pipe_in_1_bypass,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_id,
    output logic          out_last,
    output logic [DW-1:0] out_log,
    output logic [DW-1:0] out_in_0,
    output logic [DW-1:0] out_in_1,
    output logic          busy
);

    arb_state_e state_q, state_d;
    logic       rr_q, rr_d;
    logic       grant0, grant1, acc0, acc1, accept, gnt_last;
    logic       sb_any;
    sb_t        sb_in, sb_last;

    // Datapath and sideband stall together whenever a result is held.
    assign pipe_en    = out_ready | ~pipe_valid_out;
    assign grant0     = (state_q == GRANT0);
    assign grant1     = (state_q == GRANT1);
    assign req0_ready = grant0 & pipe_en;
    assign req1_ready = grant1 & pipe_en;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign accept     = acc0 | acc1;
    assign gnt_last   = grant1 ? req1_last : req0_last;

    assign pipe_valid_in = accept;
    assign pipe_in_0     = grant0 ? req0_in_0 : (grant1 ? req1_in_0 : '0);
    assign pipe_in_1     = grant0 ? req0_in_1 : (grant1 ? req1_in_1 : '0);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) state_d = rr_q ? GRANT1 : GRANT0;
                else if (req0_valid)          state_d = GRANT0;
                else if (req1_valid)          state_d = GRANT1;
            end
            GRANT0: begin
                if (acc0 && req0_last) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                end
            end
            GRANT1: begin
                if (acc1 && req1_last) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Tags are zeroed on bubbles so an empty entry reads as all-zero.
    assign sb_in = '{vld: accept, id: accept & grant1, last: accept & gnt_last};

    log2_sideband_delay #(.W(SB_W), .LAT(LAT)) u_sideband (
        .clk   (clk),
        .rst   (rst),
        .en_i  (pipe_en),
        .d_i   (sb_in),
        .q_o   (sb_last),
        .any_o (sb_any)
    );

    assign out_valid = pipe_valid_out;
    assign out_id    = sb_last.vld & sb_last.id;
    assign out_last  = sb_last.last;
    assign out_log   = pipe_log_in_0;
    assign out_in_0  = pipe_in_0_bypass;
    assign out_in_1  = pipe_in_1_bypass;
    assign busy      = (state_q != IDLE) | sb_any;

endmodule

// File: tb/tb_log2_stage_arbiter.sv
// Directed bench for log2_stage_arbiter with a 3-stage enabled log2 datapath model.
module tb_log2_stage_arbiter;
    import log2_stage_arbiter_pkg::*;

    localparam int DW  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req0_last = 1'b0;
    logic [DW-1:0] req0_in_0 = '0, req0_in_1 = '0;
    logic          req1_valid = 1'b0, req1_last = 1'b0;
    logic [DW-1:0] req1_in_0 = '0, req1_in_1 = '0;
    logic          req0_ready, req1_ready;
    logic          pipe_en, pipe_valid_in, pipe_valid_out;
    logic [DW-1:0] pipe_in_0, pipe_in_1, pipe_log_in_0, pipe_in_0_bypass, pipe_in_1_bypass;
    logic          out_valid, out_id, out_last, busy;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_log, out_in_0, out_in_1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit abort = 1'b0;
    logic [DW-1:0] in0_tbl [3] = '{16'h0100, 16'h0200, 16'h0080};

    typedef struct {
        int            cyc;
        logic          id;
        logic          last;
        logic [DW-1:0] lg;
        logic [DW-1:0] i0;
        logic [DW-1:0] i1;
    } beat_t;

    beat_t out_q[$];
    int    acc_cyc[$];

    log2_stage_arbiter #(.DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_last(req0_last),
        .req0_in_0(req0_in_0), .req0_in_1(req0_in_1),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_last(req1_last),
        .req1_in_0(req1_in_0), .req1_in_1(req1_in_1),
        .pipe_en(pipe_en), .pipe_valid_in(pipe_valid_in),
        .pipe_in_0(pipe_in_0), .pipe_in_1(pipe_in_1),
        .pipe_valid_out(pipe_valid_out), .pipe_log_in_0(pipe_log_in_0),
        .pipe_in_0_bypass(pipe_in_0_bypass), .pipe_in_1_bypass(pipe_in_1_bypass),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_last(out_last),
        .out_log(out_log), .out_in_0(out_in_0), .out_in_1(out_in_1), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mitchell log2 in Q8.8: exact on powers of two
    function automatic logic [DW-1:0] mlog2(input logic [DW-1:0] x);
        int p;
        logic [DW-1:0] sh;
        logic [7:0] ip;
        if (x == '0) return 16'h8000;
        p = 0;
        for (int i = 0; i < DW; i++) if (x[i]) p = i;
        sh = x << (15 - p);
        ip = 8'(p - 8);
        return {ip, sh[14:7]};
    endfunction

    logic          dv [LAT];
    logic [DW-1:0] dl [LAT], d0 [LAT], d1 [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                dv[i] <= 1'b0; dl[i] <= '0; d0[i] <= '0; d1[i] <= '0;
            end
        end else if (pipe_en) begin
            dv[0] <= pipe_valid_in;
            dl[0] <= mlog2(pipe_in_0);
            d0[0] <= pipe_in_0;
            d1[0] <= pipe_in_1;
            for (int i = 1; i < LAT; i++) begin
                dv[i] <= dv[i-1]; dl[i] <= dl[i-1]; d0[i] <= d0[i-1]; d1[i] <= d1[i-1];
            end
        end
    end

    assign pipe_valid_out   = dv[LAT-1];
    assign pipe_log_in_0    = dl[LAT-1];
    assign pipe_in_0_bypass = d0[LAT-1];
    assign pipe_in_1_bypass = d1[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pipe_valid_in) acc_cyc.push_back(cyc);
            if (out_valid && out_ready)
                out_q.push_back('{cyc, out_id, out_last, out_log, out_in_0, out_in_1});
            chk("sb_vld_align", {31'd0, dut.sb_last.vld}, {31'd0, pipe_valid_out});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic l,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (r == 0) begin
            req0_valid = v; req0_last = l; req0_in_0 = a; req0_in_1 = b;
        end else begin
            req1_valid = v; req1_last = l; req1_in_0 = a; req1_in_1 = b;
        end
    endtask

    task automatic drive_vec(input int r, input int n, input logic [DW-1:0] tag,
                             input bit use_tbl, input int gap_at, input int gap_len);
        int k = 0;
        int guard = 0;
        bit gap_done = 1'b0;
        bit rdy;
        logic [DW-1:0] a;
        while (k < n && guard < 60 && !abort) begin
            if (k == gap_at && gap_len > 0 && !gap_done) begin
                set_req(r, 1'b0, 1'b0, '0, '0);
                repeat (gap_len) begin
                    @(negedge clk);
                    chk("gap_other_blocked", {31'd0, req0_ready}, 32'd0);
                    chk("gap_grant_held", {31'd0, req1_ready}, 32'd1);
                    @(posedge clk);
                    #1;
                end
                gap_done = 1'b1;
            end
            a = use_tbl ? in0_tbl[k] : tag + DW'(k);
            set_req(r, 1'b1, (k == n - 1), a, tag + DW'(k));
            @(negedge clk);
            if (abort) break;
            rdy = (r == 0) ? req0_ready : req1_ready;
            @(posedge clk);
            #1;
            guard++;
            if (rdy) k++;
        end
        set_req(r, 1'b0, 1'b0, '0, '0);
        chk("drv_done", {31'd0, (k >= n) || abort}, 32'd1);
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic id,
                            input logic last, input logic [DW-1:0] i1);
        if (idx < out_q.size()) begin
            chk({tag, "_id"}, {31'd0, out_q[idx].id}, {31'd0, id});
            chk({tag, "_last"}, {31'd0, out_q[idx].last}, {31'd0, last});
            chk({tag, "_in1"}, {16'd0, out_q[idx].i1}, {16'd0, i1});
        end else begin
            chk({tag, "_missing"}, idx, out_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int ob, ab, g;
        logic [DW-1:0] exp_log [3];
        logic [15:0] t3 [8];
        logic [15:0] t5 [5];
        exp_log = '{16'h0000, 16'h0100, 16'hFF00};
        t3 = '{16'h4000, 16'h4001, 16'h5000, 16'h5001, 16'h4100, 16'h4101, 16'h5100, 16'h5101};
        t5 = '{16'h6000, 16'h6001, 16'h6002, 16'h7000, 16'h7001};

        // reset state
        step(2);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pipe_vin", {31'd0, pipe_valid_in}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_id", {31'd0, out_id}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        rst = 1'b0;
        step(1);

        // single requester, 3-beat vector
        ob = out_q.size(); ab = acc_cyc.size();
        drive_vec(0, 3, 16'h0A00, 1'b1, -1, 0);
        step(6);
        chk("t1_count", out_q.size() - ob, 32'd3);
        for (int k = 0; k < 3 && ob + k < out_q.size() && ab + k < acc_cyc.size(); k++) begin
            chk("t1_log", {16'd0, out_q[ob+k].lg}, {16'd0, exp_log[k]});
            chk("t1_in0", {16'd0, out_q[ob+k].i0}, {16'd0, in0_tbl[k]});
            chk("t1_latency", out_q[ob+k].cyc - acc_cyc[ab+k], 32'd3);
        end
        chk_beat("t1_b0", ob, 1'b0, 1'b0, 16'h0A00);
        chk_beat("t1_b2", ob + 2, 1'b0, 1'b1, 16'h0A02);
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);

        // both valid at reset release
        rst = 1'b1;
        ob = out_q.size(); ab = acc_cyc.size();
        fork
            drive_vec(0, 2, 16'h1000, 1'b0, -1, 0);
            drive_vec(1, 2, 16'h2000, 1'b0, -1, 0);
        join_none
        step(2);
        rst = 1'b0;
        wait fork;
        step(6);
        chk("t2_count", out_q.size() - ob, 32'd4);
        chk_beat("t2_b0", ob, 1'b0, 1'b0, 16'h1000);
        chk_beat("t2_b1", ob + 1, 1'b0, 1'b1, 16'h1001);
        chk_beat("t2_b2", ob + 2, 1'b1, 1'b0, 16'h2000);
        chk_beat("t2_b3", ob + 3, 1'b1, 1'b1, 16'h2001);
        if (acc_cyc.size() - ab >= 3) begin
            chk("t2_back_to_back", acc_cyc[ab+1] - acc_cyc[ab], 32'd1);
            chk("t2_bubble", acc_cyc[ab+2] - acc_cyc[ab+1], 32'd2);
        end else begin
            chk("t2_acc_count", acc_cyc.size() - ab, 32'd4);
        end

        // both always valid for 4 vectors: alternating grants
        ob = out_q.size();
        fork
            begin
                drive_vec(0, 2, 16'h4000, 1'b0, -1, 0);
                drive_vec(0, 2, 16'h4100, 1'b0, -1, 0);
            end
            begin
                drive_vec(1, 2, 16'h5000, 1'b0, -1, 0);
                drive_vec(1, 2, 16'h5100, 1'b0, -1, 0);
            end
        join
        step(6);
        chk("t3_count", out_q.size() - ob, 32'd8);
        for (int k = 0; k < 8; k++)
            chk_beat("t3", ob + k, t3[k][8] ? t3[k][12] : t3[k][12], k[0], t3[k]);

        // backpressure with 3 beats in flight
        out_ready = 1'b0;
        ob = out_q.size(); ab = acc_cyc.size();
        fork
            drive_vec(0, 4, 16'h3000, 1'b0, -1, 0);
        join_none
        g = 0;
        while (!out_valid && g < 20) begin
            step(1);
            g++;
        end
        chk("t4_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (5) begin
            chk("t4_pipe_en", {31'd0, pipe_en}, 32'd0);
            chk("t4_req0_ready", {31'd0, req0_ready}, 32'd0);
            chk("t4_hold_log", {16'd0, out_log}, 32'h0580);
            chk("t4_hold_in0", {16'd0, out_in_0}, 32'h3000);
            chk("t4_hold_in1", {16'd0, out_in_1}, 32'h3000);
            chk("t4_hold_id", {31'd0, out_id}, 32'd0);
            step(1);
        end
        chk("t4_in_flight", acc_cyc.size() - ab, 32'd3);
        out_ready = 1'b1;
        wait fork;
        step(6);
        chk("t4_count", out_q.size() - ob, 32'd4);
        for (int k = 0; k < 4; k++)
            chk_beat("t4", ob + k, 1'b0, (k == 3), 16'h3000 + 16'(k));

        // requester 1 pauses mid-vector, grant held
        ob = out_q.size(); ab = acc_cyc.size();
        fork
            drive_vec(1, 3, 16'h6000, 1'b0, 1, 4);
            drive_vec(0, 2, 16'h7000, 1'b0, -1, 0);
        join
        step(6);
        chk("t5_count", out_q.size() - ob, 32'd5);
        for (int k = 0; k < 5; k++)
            chk_beat("t5", ob + k, (k < 3), (k == 2 || k == 4), t5[k]);
        if (acc_cyc.size() - ab >= 4)
            chk("t5_bubble", acc_cyc[ab+3] - acc_cyc[ab+2], 32'd2);
        else
            chk("t5_acc_count", acc_cyc.size() - ab, 32'd5);
        chk("t5_busy_idle", {31'd0, busy}, 32'd0);

        // reset with 2 beats in flight mid-vector
        ob = out_q.size(); ab = acc_cyc.size();
        abort = 1'b0;
        fork
            drive_vec(0, 4, 16'h8000, 1'b0, -1, 0);
        join_none
        g = 0;
        while (acc_cyc.size() - ab < 2 && g < 30) begin
            step(1);
            g++;
        end
        chk("t6_in_flight", acc_cyc.size() - ab, 32'd2);
        abort = 1'b1;
        rst = 1'b1;
        step(1);
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        chk("t6_req0_ready", {31'd0, req0_ready}, 32'd0);
        rst = 1'b0;
        wait fork;
        abort = 1'b0;
        step(8);
        chk("t6_no_stale", out_q.size() - ob, 32'd0);
        chk("t6_busy_after", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
